bla_serial_sub: RTL and testbench

Multi-cycle subtractor computing `a - b - bin` on WIDTH-bit operands, one 4-bit borrow-lookahead slice per clock, with the inter-slice borrow held in a register. It is the subtract-side counterpart of the team's 4-bit carry-lookahead adder and sits in the adders library for datapaths that trade latency for area. It uses a start/busy/done handshake and holds its results stable between operations.

---
 rtl/adder_pkg.sv | 16 +
 rtl/bla_slice4.sv | 33 +++
 rtl/bla_serial_sub.sv | 126 ++++++++++++
 tb/tb_bla_serial_sub.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adders library: slice width,
// serial-unit state encoding and slice-count helper.
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/bla_slice4.sv
// Combinational 4-bit borrow-lookahead subtract slice:
// d = a - b - bi over one nibble, bo = borrow out of bit 3.
module bla_slice4
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bi,
    output logic [SLICE_W-1:0] d,
    output logic               bo
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   br;

    assign g = ~a & b;
    assign p = ~a | b;

    // Flattened lookahead: every borrow is two gate levels from bi.
    assign br[0] = bi;
    assign br[1] = g[0] | (p[0] & bi);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bi);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bi);

    assign d  = a ^ b ^ br[SLICE_W-1:0];
    assign bo = br[SLICE_W];

endmodule

// File: rtl/bla_serial_sub.sv
// Serial subtractor: a - b - bin, one 4-bit lookahead slice
// per clock, inter-slice borrow held in a register.
module bla_serial_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = slice_count(WIDTH);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_d;
    logic               sl_bo;

    always_comb begin
        sl_a = a_q[SLICE_W*int'(k_q) +: SLICE_W];
        sl_b = b_q[SLICE_W*int'(k_q) +: SLICE_W];
    end

    bla_slice4 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .bi (bor_q),
        .d  (sl_d),
        .bo (sl_bo)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        bor_d   = bor_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    bor_d   = bin;
                    k_d     = '0;
                end
            end
            RUN: begin
                res_d[SLICE_W*int'(k_q) +: SLICE_W] = sl_d;
                bor_d = sl_bo;
                k_d   = k_q + KW'(1);
                // Publish only the complete word, never a partial one.
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                    k_d     = '0;
                    diff_d  = res_d;
                    bout_d  = sl_bo;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                           && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            bor_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            bor_q   <= bor_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bla_serial_sub.sv
// Scoreboard bench for bla_serial_sub (WIDTH 16 and WIDTH 4).
module tb_bla_serial_sub;

    localparam int W  = 16;
    localparam int NS = W / 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_until = 0;
    exp_t q[$];
    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;
    logic         last_ov = 1'b0;

    bla_serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    bla_serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input longint ua,
                                   input longint ub, input longint ubin);
        exp_t e;
        longint m, r, sa, sb, sr;
        m    = (longint'(1) << w) - 1;
        r    = (ua - ub - ubin) & m;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (m + 1) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (m + 1) : ub;
        sr   = sa - sb - ubin;
        e.d  = W'(r);
        e.bo = (ua < ub + ubin);
        e.ov = (sr < -(longint'(1) << (w - 1))) || (sr >= (longint'(1) << (w - 1)));
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops on done, otherwise checks outputs are held.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, (cyc < busy_until));
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.bo);
                    chk("ovf", ovf, e.ov);
                    last_d  = e.d;
                    last_bo = e.bo;
                    last_ov = e.ov;
                end
            end else begin
                chk("hold", {diff, bout, ovf}, {last_d, last_bo, last_ov});
                if (q.size() != 0 && cyc >= q[0].cyc) begin
                    chk("missing_done", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at T0+1.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tbin);
        exp_t e;
        start = 1'b1;
        a = ta;
        b = tb;
        bin = tbin;
        @(posedge clk);
        #1;
        e = model(W, longint'(ta), longint'(tb), longint'(tbin));
        e.cyc = cyc + NS;
        busy_until = cyc + NS;
        q.push_back(e);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic run_rest(input int extra);
        for (int j = 0; j < NS + extra; j++) begin
            @(posedge clk);
            #1;
            a = W'($urandom);
            b = W'($urandom);
        end
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        exp_t e;
        e = model(4, longint'(ta), longint'(tb), longint'(tbin));
        start4 = 1'b1;
        a4 = ta;
        b4 = tb;
        bin4 = tbin;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        chk("w4_busy_run", busy4, 1);
        chk("w4_done_early", done4, 0);
        @(posedge clk);
        #1;
        chk("w4_done", done4, 1);
        chk("w4_busy_end", busy4, 0);
        chk("w4_diff", diff4, e.d[3:0]);
        chk("w4_bout", bout4, e.bo);
        chk("w4_ovf", ovf4, e.ov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        start_op(16'h0000, 16'h0001, 1'b0);
        run_rest(1);
        start_op(16'h8000, 16'h0001, 1'b0);
        run_rest(1);
        start_op(16'h1000, 16'h0FFF, 1'b1);
        run_rest(1);
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        run_rest(1);

        // Start while busy must be ignored.
        start_op(16'h1234, 16'h0235, 1'b0);
        start = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        run_rest(-2);
        // Back-to-back: start during the done cycle.
        start_op(16'h7FFF, 16'hFFFF, 1'b0);
        run_rest(0);
        start_op(16'h0001, 16'h8000, 1'b1);
        run_rest(1);

        for (int i = 0; i < 40; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            run_rest(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset mid-operation.
        start_op(16'h4321, 16'h1234, 1'b0);
        run_rest(1);
        start_op(16'h0F0F, 16'h1F1F, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        busy_until = 0;
        last_d = '0;
        last_bo = 1'b0;
        last_ov = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_diff", diff, 0);
        chk("arst_bout", bout, 0);
        chk("arst_ovf", ovf, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(16'hBEEF, 16'hCAFE, 1'b1);
        run_rest(1);

        op4(4'b1001, 4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
